// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encoding,
// mstatus bit positions and the read-modify-write helper.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    // Operands are carried at 64 bits so any XLEN up to 64 can share this helper.
    function automatic logic [63:0] csr_apply(input csr_op_e op,
                                              input logic [63:0] old_val,
                                              input logic [63:0] wdata);
        logic [63:0] res;
        case (op)
            CSR_WRITE: res = wdata;
            CSR_SET:   res = old_val | wdata;
            CSR_CLEAR: res = old_val & ~wdata;
            default:   res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit performance counter with independently writable 32-bit halves.
// A write to either half suppresses the increment for that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // Reset, then half-writes, then increment with full 64-bit carry/wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wdata;
            if (wr_hi) count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_trap_file.sv
// Machine-mode CSR file with trap entry / mret sequencing and mcycle/minstret.
// Optional macro CSR_VECTORED_EN: enables vectored mtvec mode for interrupts.
module csr_trap_file
    import csr_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] MSTATUS_RESET = 32'h0000_1800,
    parameter logic [XLEN-1:0] MTVEC_RESET   = 32'h0000_0000,
    parameter logic [XLEN-1:0] HARTID        = '0,
    parameter logic [XLEN-1:0] MVENDORID     = '0,
    parameter logic [XLEN-1:0] MARCHID       = 32'h0189_13E5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            retire,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [XLEN-1:0] mstatus_rd, new_val, trap_base;
    logic [63:0]     mcycle, minstret;
    logic            mapped, op_active, wr_en;

    // Only the two mode bits of mtvec are ever legal; 1x reads back as direct.
    function automatic logic [XLEN-1:0] mtvec_warl(input logic [XLEN-1:0] v);
`ifdef CSR_VECTORED_EN
        return (v & ~XLEN'(3)) | ((v[1:0] == 2'b01) ? XLEN'(1) : '0);
`else
        return v & ~XLEN'(3);
`endif
    endfunction

    // mstatus view: MIE/MPIE stored, MPP hardwired to machine mode.
    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MIE]         = mie_q;
        mstatus_rd[MSTATUS_MPIE]        = mpie_q;
        mstatus_rd[MSTATUS_MPP_LO +: 2] = 2'b11;
    end

    // Address decode and read mux; unmapped addresses read zero.
    always_comb begin
        csr_rdata = '0;
        mapped    = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = mstatus_rd;
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MSCRATCH:  csr_rdata = mscratch_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MCYCLE:    csr_rdata = XLEN'(mcycle[31:0]);
            CSR_MCYCLEH:   csr_rdata = XLEN'(mcycle[63:32]);
            CSR_MINSTRET:  csr_rdata = XLEN'(minstret[31:0]);
            CSR_MINSTRETH: csr_rdata = XLEN'(minstret[63:32]);
            CSR_MVENDORID: csr_rdata = MVENDORID;
            CSR_MARCHID:   csr_rdata = MARCHID;
            CSR_MHARTID:   csr_rdata = HARTID;
            default:       mapped    = 1'b0;
        endcase
    end

    // Illegal flag and write qualification; traps and mret shadow CSR writes.
    always_comb begin
        op_active   = (csr_op != CSR_NONE);
        csr_illegal = !rst && op_active && ((csr_addr[11:10] == 2'b11) || !mapped);
        wr_en       = op_active && !csr_illegal && !trap_valid && !mret_valid;
        new_val     = XLEN'(csr_apply(csr_op_e'(csr_op), 64'(csr_rdata), 64'(csr_wdata)));
    end

    // Fetch redirect: trap vector (direct or vectored) or saved mepc on mret.
    always_comb begin
        redirect_valid = !rst && (trap_valid || mret_valid);
        trap_base      = {mtvec_q[XLEN-1:2], 2'b00};
        if (trap_valid) begin
            redirect_pc = trap_base;
`ifdef CSR_VECTORED_EN
            if (mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1])
                redirect_pc = trap_base + XLEN'({trap_cause[5:0], 2'b00});
`endif
        end else begin
            redirect_pc = mepc_q;
        end
    end

    // CSR state update: reset > trap > mret > software write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= MSTATUS_RESET[MSTATUS_MIE];
            mpie_q     <= MSTATUS_RESET[MSTATUS_MPIE];
            mtvec_q    <= mtvec_warl(MTVEC_RESET);
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (trap_valid) begin
            mepc_q   <= trap_pc & ~XLEN'(3);
            mcause_q <= trap_cause;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret_valid) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_q  <= new_val[MSTATUS_MIE];
                    mpie_q <= new_val[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_q    <= mtvec_warl(new_val);
                CSR_MSCRATCH: mscratch_q <= new_val;
                CSR_MEPC:     mepc_q     <= new_val & ~XLEN'(3);
                CSR_MCAUSE:   mcause_q   <= new_val;
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (wr_en && csr_addr == CSR_MCYCLE),
        .wr_hi (wr_en && csr_addr == CSR_MCYCLEH),
        .wdata (new_val[31:0]),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .wr_lo (wr_en && csr_addr == CSR_MINSTRET),
        .wr_hi (wr_en && csr_addr == CSR_MINSTRETH),
        .wdata (new_val[31:0]),
        .count (minstret)
    );

endmodule

// File: tb/tb_csr_trap_file.sv
// Self-checking bench for csr_trap_file. Read expectations go through a
// scoreboard queue; vectored-mode checks are compiled with CSR_VECTORED_EN.
module tb_csr_trap_file;

    localparam logic [31:0] TB_HARTID = 32'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_illegal;
    logic        trap_valid, mret_valid, retire;
    logic [31:0] trap_cause, trap_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ms_model;

    csr_trap_file #(.HARTID(TB_HARTID)) dut (
        .clk            (clk),
        .rst            (rst),
        .csr_addr       (csr_addr),
        .csr_op         (csr_op),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .trap_valid     (trap_valid),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .mret_valid     (mret_valid),
        .retire         (retire),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        csr_op     = 2'b00;
        csr_wdata  = '0;
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        retire     = 1'b0;
    endtask

    task automatic idle(input logic ret);
        @(negedge clk);
        clr();
        retire = ret;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        clr();
        csr_addr = a;
        sb_q.push_back('{tag, exp});
        #1;
        e = sb_q.pop_front();
        chk(e.tag, csr_rdata, e.exp);
    endtask

    // Both halves in one cycle so a counter is seen coherently.
    task automatic rd64(input string tag, input logic [11:0] a_lo, input logic [11:0] a_hi,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        exp_t e;
        @(negedge clk);
        clr();
        sb_q.push_back('{{tag, "_lo"}, exp_lo});
        sb_q.push_back('{{tag, "_hi"}, exp_hi});
        csr_addr = a_lo;
        #1;
        e = sb_q.pop_front();
        chk(e.tag, csr_rdata, e.exp);
        csr_addr = a_hi;
        #1;
        e = sb_q.pop_front();
        chk(e.tag, csr_rdata, e.exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d,
                      input logic exp_ill);
        @(negedge clk);
        clr();
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = d;
        #1;
        chk("illegal", {31'd0, csr_illegal}, {31'd0, exp_ill});
    endtask

    task automatic trap(input logic [31:0] cause, input logic [31:0] pc,
                        input logic [31:0] exp_pc, input logic with_wr);
        @(negedge clk);
        clr();
        trap_valid = 1'b1;
        trap_cause = cause;
        trap_pc    = pc;
        if (with_wr) begin
            csr_addr  = 12'h340;
            csr_op    = 2'b01;
            csr_wdata = 32'h1111_1111;
        end
        #1;
        chk("trap_rv", {31'd0, redirect_valid}, 32'd1);
        chk("trap_pc", redirect_pc, exp_pc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        trap_valid = 1'b1;
        mret_valid = 1'b1;
        csr_addr   = 12'hF14;
        csr_op     = 2'b01;
        csr_wdata  = 32'h0000_0055;
        retire     = 1'b1;
        #1;
        chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst_ill", {31'd0, csr_illegal}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clr();
        ms_model = '0;
    endtask

    initial begin
        rst = 1'b1;
        csr_addr = '0;
        trap_cause = '0;
        trap_pc = '0;
        clr();

        do_reset();
        rd64("mcycle_after_rst", 12'hB00, 12'hB80, 32'd1, 32'd0);
        rd("mstatus_rst", 12'h300, 32'h0000_1800);
        rd("mtvec_rst", 12'h305, 32'h0000_0000);
        rd("mepc_rst", 12'h341, 32'h0);
        rd("mhartid", 12'hF14, TB_HARTID);
        rd("mvendorid", 12'hF11, 32'h0);
        rd("marchid", 12'hF12, 32'h0189_13E5);
        rd("unmapped", 12'h123, 32'h0);

        wr(12'h340, 2'b01, 32'hA5A5_0000, 1'b0);
        wr(12'h340, 2'b10, 32'h0000_00FF, 1'b0);
        rd("mscratch_set", 12'h340, 32'hA5A5_00FF);
        wr(12'h340, 2'b11, 32'hA500_0000, 1'b0);
        rd("mscratch_clr", 12'h340, 32'h00A5_00FF);
        ms_model = 32'h00A5_00FF;

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  op;
            logic [31:0] d;
            op = 2'($urandom_range(1, 3));
            d  = $urandom;
            wr(12'h340, op, d, 1'b0);
            case (op)
                2'b01:   ms_model = d;
                2'b10:   ms_model = ms_model | d;
                default: ms_model = ms_model & ~d;
            endcase
            rd("mscratch_rand", 12'h340, ms_model);
        end

        wr(12'hF14, 2'b01, 32'hDEAD_BEEF, 1'b1);
        rd("mhartid_ro", 12'hF14, TB_HARTID);
        wr(12'h123, 2'b10, 32'h1, 1'b1);
        wr(12'hB00, 2'b00, 32'h1, 1'b0);

        wr(12'h300, 2'b01, 32'hFFFF_FFFF, 1'b0);
        rd("mstatus_warl", 12'h300, 32'h0000_1888);
        wr(12'h300, 2'b11, 32'h0000_0088, 1'b0);
        rd("mstatus_clr", 12'h300, 32'h0000_1800);
        wr(12'h341, 2'b01, 32'h0000_1237, 1'b0);
        rd("mepc_warl", 12'h341, 32'h0000_1234);
        wr(12'h305, 2'b01, 32'h8000_0103, 1'b0);
        rd("mtvec_warl", 12'h305, 32'h8000_0100);

        wr(12'h305, 2'b01, 32'h8000_0100, 1'b0);
        wr(12'h300, 2'b10, 32'h0000_0008, 1'b0);
        trap(32'd11, 32'h8000_0042, 32'h8000_0100, 1'b1);
        rd("mepc_trap", 12'h341, 32'h8000_0040);
        rd("mcause_trap", 12'h342, 32'd11);
        rd("mstatus_trap", 12'h300, 32'h0000_1880);
        rd("mscratch_prio", 12'h340, ms_model);

        @(negedge clk);
        clr();
        mret_valid = 1'b1;
        csr_addr   = 12'h340;
        csr_op     = 2'b01;
        csr_wdata  = 32'h2222_2222;
        #1;
        chk("mret_rv", {31'd0, redirect_valid}, 32'd1);
        chk("mret_pc", redirect_pc, 32'h8000_0040);
        rd("mstatus_mret", 12'h300, 32'h0000_1888);
        rd("mscratch_mret", 12'h340, ms_model);

        wr(12'hB00, 2'b01, 32'hFFFF_FFFE, 1'b0);
        wr(12'hB80, 2'b01, 32'h0000_0000, 1'b0);
        rd64("mcycle_hold", 12'hB00, 12'hB80, 32'hFFFF_FFFE, 32'h0);
        idle(1'b0);
        rd64("mcycle_carry", 12'hB00, 12'hB80, 32'h0, 32'h1);

        wr(12'hB02, 2'b01, 32'd5, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        rd64("minstret", 12'hB02, 12'hB82, 32'd8, 32'd0);
        wr(12'hB82, 2'b01, 32'hFFFF_FFFF, 1'b0);
        wr(12'hB02, 2'b01, 32'hFFFF_FFFF, 1'b0);
        idle(1'b1);
        rd64("minstret_wrap", 12'hB02, 12'hB82, 32'd0, 32'd0);

`ifdef CSR_VECTORED_EN
        wr(12'h305, 2'b01, 32'h0000_0101, 1'b0);
        rd("mtvec_vec", 12'h305, 32'h0000_0101);
        trap(32'h8000_0007, 32'h0000_0200, 32'h0000_011C, 1'b0);
        trap(32'h0000_0002, 32'h0000_0204, 32'h0000_0100, 1'b0);
`else
        wr(12'h305, 2'b01, 32'h0000_0101, 1'b0);
        rd("mtvec_direct", 12'h305, 32'h0000_0100);
        trap(32'h8000_0007, 32'h0000_0200, 32'h0000_0100, 1'b0);
`endif

        do_reset();
        rd("mstatus_rst2", 12'h300, 32'h0000_1800);
        rd("mepc_rst2", 12'h341, 32'h0);
        rd("mcause_rst2", 12'h342, 32'h0);
        rd("mscratch_rst2", 12'h340, 32'h0);
        rd("mtvec_rst2", 12'h305, 32'h0);
        rd64("minstret_rst2", 12'hB02, 12'hB82, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
